jtag_bank_buffer: RTL and testbench
===================================

Name: jtag_bank_buffer

Overview:
Parametrised N-bank successor to the two-bank ping-pong buffer between the JTAG ipcore (port A, producer) and the DMA (port B, consumer). Banks circulate in strict ring order. Port A fills a bank and commits it with a word count. Port B drains committed banks oldest-first and releases them, so the JTAG side can run up to NUM_BANKS-1 banks ahead of the bus.

Parameters:
DATA_WIDTH, 32, word width of both ports
BANK_DEPTH, 512, words per bank, power of 2, >=2
NUM_BANKS, 2, bank count, power of 2, 2..8
ADDR_WIDTH, $clog2(BANK_DEPTH), in-bank address width (derived, do not override)

Ports:
clock  in  1  JTCK domain clock
reset  in  1  asynchronous active-low reset (JRSTN)
addressA  in  ADDR_WIDTH  in-bank address, port A
writeEnableA  in  1  write dataInA to A's bank
dataInA  in  DATA_WIDTH  write data, port A
dataOutA  out  DATA_WIDTH  registered read data, port A
commitA  in  1  hand A's current bank to port B
commitLengthA  in  ADDR_WIDTH+1  valid words in committed bank (1..BANK_DEPTH)
bankValidA  out  1  port A currently owns a bank
addressB  in  ADDR_WIDTH  in-bank address, port B
writeEnableB  in  1  write dataInB to B's bank
dataInB  in  DATA_WIDTH  write data, port B
dataOutB  out  DATA_WIDTH  registered read data, port B
releaseB  in  1  return B's current bank to the free pool
bankValidB  out  1  port B currently owns a committed bank
bankLengthB  out  ADDR_WIDTH+1  commitLength of B's bank, 0 when bankValidB low
occupancy  out  $clog2(NUM_BANKS)+1  committed, unreleased banks
overflowError  out  1  sticky: commit while bankValidA low
underflowError  out  1  sticky: release while bankValidB low
clearErrors  in  1  synchronous clear of both sticky flags

Behaviour:
- State: wrPtr, rdPtr (log2 NUM_BANKS bits, wrap modulo NUM_BANKS), occ (0..NUM_BANKS), length register per bank.
- bankValidA = (occ < NUM_BANKS); bankValidB = (occ > 0); occupancy = occ. All combinational from registers.
- A accesses physical bank wrPtr; B accesses bank rdPtr. Both valid implies wrPtr != rdPtr, so no cross-port address collision.
- Reset (async assert, sync-release assumed upstream): wrPtr=rdPtr=occ=0, all lengths=0, dataOutA=dataOutB=0, both errors=0. Memory contents are not reset. After reset A owns bank 0 and B owns none.
- Reads: dataOutX <= mem[{ptr,addressX}] every cycle, 1-cycle latency. Same-port read and write to the same address return the old data (read-first). Output data is meaningless when that port's bankValid was low.
- Writes ignored while that port's bankValid is low.
- commitA with bankValidA: length[wrPtr] <= commitLengthA, wrPtr++, occ++. commitLengthA values of 0 or above BANK_DEPTH are clamped to BANK_DEPTH.
- commitA without bankValidA: no state change; overflowError <= 1.
- releaseB with bankValidB: length[rdPtr] <= 0, rdPtr++, occ--.
- releaseB without bankValidB: no state change; underflowError <= 1.
- Simultaneous valid commit and release: both pointers advance and occ is unchanged.
- occ==0 with simultaneous commit and release: commit takes effect, release flags underflow.
- occ==NUM_BANKS with simultaneous commit and release: release takes effect, commit flags overflow. bankValidA rises the next cycle.
- A write and commit in the same cycle: the write lands in the bank being committed.
- Pointer and ownership changes are visible the cycle after the event.
- clearErrors has priority below a same-cycle new error: the error stays set.
- Reset mid-operation discards all ownership; uncommitted and committed data are abandoned.

Optional Feature:
JTAG_BANK_AUTOCOMMIT_EN:
- Defined: a port-A write to address BANK_DEPTH-1 while bankValidA is high is treated as commitA with length BANK_DEPTH in the same cycle. It is ORed with an explicit commitA; commitLengthA is ignored that cycle.
- Undefined: commits occur only on commitA; a write to the last address has no side effect.

Test Plan:
1. Reset, NUM_BANKS=4: bankValidA=1, bankValidB=0, occupancy=0. Write 0xA5A5_0000+i to addresses 0..9, commit with length 10 -> bankValidB=1, bankLengthB=10; B read addr 3 returns 0xA5A50003 one cycle later.
2. Four commits, no releases -> occupancy=4, bankValidA=0. A write to addr 0 is dropped (B later reads the original bank-0 data). A fifth commit sets overflowError=1.
3. occupancy=2, commit and release in the same cycle -> occupancy stays 2, rdPtr=1 (B sees the second bank's length), wrPtr=3.
4. Release at occupancy=0 -> underflowError=1, state unchanged. clearErrors pulse -> 0. Error and clear in the same cycle -> remains 1.
5. With JTAG_BANK_AUTOCOMMIT_EN, BANK_DEPTH=16: write addr 15 -> occupancy=1, bankLengthB=16. Without the macro, occupancy stays 0.
6. Reset asserted at occupancy=3 mid-burst -> all outputs return to reset values asynchronously; bankValidA=1 immediately.

Source files
------------

// File: rtl/jtag_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module      : jtag_bank_buffer
// Description : N-bank ring buffer between the JTAG ipcore (port A, producer)
//               and the DMA (port B, consumer). Port A fills the bank at
//               the write pointer and commits it with a word count. Port B
//               drains committed banks oldest-first and releases them.
//               Both ports are synchronous RAM ports with 1-cycle,
//               read-first read data.
// Ports       : clock/reset           - JTCK clock, async active-low reset
//               addressA/writeEnableA/dataInA/dataOutA - port A RAM access
//               commitA/commitLengthA  - hand the current A bank to B
//               bankValidA             - A owns a bank
//               addressB/writeEnableB/dataInB/dataOutB - port B RAM access
//               releaseB               - return the current B bank
//               bankValidB/bankLengthB - B owns a bank, and its length
//               occupancy              - committed, unreleased banks
//               overflowError/underflowError/clearErrors - sticky errors
// Options     : JTAG_BANK_AUTOCOMMIT_EN - a valid port-A write to the last
//               address of a bank also commits it with length BANK_DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_bank_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 512,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = $clog2(BANK_DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        addressA,
  input  logic                         writeEnableA,
  input  logic [DATA_WIDTH-1:0]        dataInA,
  output logic [DATA_WIDTH-1:0]        dataOutA,
  input  logic                         commitA,
  input  logic [ADDR_WIDTH:0]          commitLengthA,
  output logic                         bankValidA,
  input  logic [ADDR_WIDTH-1:0]        addressB,
  input  logic                         writeEnableB,
  input  logic [DATA_WIDTH-1:0]        dataInB,
  output logic [DATA_WIDTH-1:0]        dataOutB,
  input  logic                         releaseB,
  output logic                         bankValidB,
  output logic [ADDR_WIDTH:0]          bankLengthB,
  output logic [$clog2(NUM_BANKS):0]   occupancy,
  output logic                         overflowError,
  output logic                         underflowError,
  input  logic                         clearErrors
);

  localparam int PTR_W = $clog2(NUM_BANKS);
  localparam int OCC_W = PTR_W + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam int MEM_WORDS = NUM_BANKS * BANK_DEPTH;

  localparam logic [OCC_W-1:0] c_full  = OCC_W'(NUM_BANKS);
  localparam logic [LEN_W-1:0] c_depth = LEN_W'(BANK_DEPTH);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic [LEN_W-1:0]      r_len [NUM_BANKS];
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_dout_a;
  logic [DATA_WIDTH-1:0] r_dout_b;
  logic                  r_ovf;
  logic                  r_unf;

  logic                        w_valid_a;
  logic                        w_valid_b;
  logic                        w_auto;
  logic                        w_commit_req;
  logic                        w_do_commit;
  logic                        w_do_release;
  logic [LEN_W-1:0]            w_commit_len;
  logic [PTR_W+ADDR_WIDTH-1:0] w_addr_a;
  logic [PTR_W+ADDR_WIDTH-1:0] w_addr_b;

  // Both valid implies the pointers differ, so A and B never share a bank.
  assign w_valid_a = (r_occ < c_full);
  assign w_valid_b = (r_occ != '0);
  assign w_addr_a  = {r_wr_ptr, addressA};
  assign w_addr_b  = {r_rd_ptr, addressB};

`ifdef JTAG_BANK_AUTOCOMMIT_EN
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(BANK_DEPTH - 1);
  assign w_auto = writeEnableA & w_valid_a & (addressA == c_last_addr);
`else
  assign w_auto = 1'b0;
`endif

  assign w_commit_req = commitA | w_auto;
  assign w_do_commit  = w_commit_req & w_valid_a;
  assign w_do_release = releaseB & w_valid_b;

  // A full-bank autocommit overrides the requested length; out-of-range
  // lengths (0 or beyond the bank) mean "whole bank".
  always_comb begin
    w_commit_len = commitLengthA;
    if (w_auto || (commitLengthA == '0) || (commitLengthA > c_depth)) begin
      w_commit_len = c_depth;
    end
  end

  // Bank ownership, lengths and sticky errors.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_len[i] <= '0;
      end
    end else begin
      if (w_do_release) begin
        r_len[r_rd_ptr] <= '0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_do_commit) begin
        r_len[r_wr_ptr] <= w_commit_len;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      case ({w_do_commit, w_do_release})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      // A new error in the same cycle wins over the clear.
      r_ovf <= (w_commit_req & ~w_valid_a) | (r_ovf & ~clearErrors);
      r_unf <= (releaseB & ~w_valid_b) | (r_unf & ~clearErrors);
    end
  end

  // Storage is not reset; contents of abandoned banks are simply stale.
  always_ff @(posedge clock) begin
    if (writeEnableA && w_valid_a) begin
      r_mem[w_addr_a] <= dataInA;
    end
    if (writeEnableB && w_valid_b) begin
      r_mem[w_addr_b] <= dataInB;
    end
  end

  // Read-first: a same-cycle write to the same address returns old data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dout_a <= '0;
      r_dout_b <= '0;
    end else begin
      r_dout_a <= r_mem[w_addr_a];
      r_dout_b <= r_mem[w_addr_b];
    end
  end

  assign dataOutA       = r_dout_a;
  assign dataOutB       = r_dout_b;
  assign bankValidA     = w_valid_a;
  assign bankValidB     = w_valid_b;
  assign bankLengthB    = w_valid_b ? r_len[r_rd_ptr] : '0;
  assign occupancy      = r_occ;
  assign overflowError  = r_ovf;
  assign underflowError = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_bank_buffer
// Description : Self-checking bench for jtag_bank_buffer (4 banks x 16 words).
//               A reference model tracks total commits/releases, a FIFO of
//               committed lengths and a per-bank word array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_bank_buffer;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int NB = 4;
  localparam int AW = 4;

`ifdef JTAG_BANK_AUTOCOMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addressA = '0;
  logic          writeEnableA = 1'b0;
  logic [DW-1:0] dataInA = '0;
  logic [DW-1:0] dataOutA;
  logic          commitA = 1'b0;
  logic [AW:0]   commitLengthA = '0;
  logic          bankValidA;
  logic [AW-1:0] addressB = '0;
  logic          writeEnableB = 1'b0;
  logic [DW-1:0] dataInB = '0;
  logic [DW-1:0] dataOutB;
  logic          releaseB = 1'b0;
  logic          bankValidB;
  logic [AW:0]   bankLengthB;
  logic [2:0]    occupancy;
  logic          overflowError;
  logic          underflowError;
  logic          clearErrors = 1'b0;

  jtag_bank_buffer #(
    .DATA_WIDTH(DW), .BANK_DEPTH(D), .NUM_BANKS(NB)
  ) dut (
    .clock(clk), .reset(rst_n),
    .addressA(addressA), .writeEnableA(writeEnableA), .dataInA(dataInA),
    .dataOutA(dataOutA), .commitA(commitA), .commitLengthA(commitLengthA),
    .bankValidA(bankValidA),
    .addressB(addressB), .writeEnableB(writeEnableB), .dataInB(dataInB),
    .dataOutB(dataOutB), .releaseB(releaseB), .bankValidB(bankValidB),
    .bankLengthB(bankLengthB), .occupancy(occupancy),
    .overflowError(overflowError), .underflowError(underflowError),
    .clearErrors(clearErrors)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NB][D];
  bit            m_wr  [NB][D];
  int            commits, releases;
  int            q_len[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] e_doa, e_dob;
  bit            k_doa, k_dob;

  task automatic idle();
    writeEnableA = 0; writeEnableB = 0; commitA = 0; releaseB = 0;
    clearErrors = 0; commitLengthA = '0; addressA = '0; addressB = '0;
  endtask

  task automatic model_reset();
    commits = 0; releases = 0; q_len.delete();
    m_ovf = 0; m_unf = 0;
    e_doa = '0; e_dob = '0; k_doa = 1; k_dob = 1;
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit va, vb, auto_c, req;
    int wb, rb, occ, len;
    occ = commits - releases;
    va = occ < NB;
    vb = occ > 0;
    wb = commits % NB;
    rb = releases % NB;
    k_doa = va && m_wr[wb][addressA]; e_doa = m_mem[wb][addressA];
    k_dob = vb && m_wr[rb][addressB]; e_dob = m_mem[rb][addressB];
    auto_c = AUTO && writeEnableA && va && (int'(addressA) == D - 1);
    if (writeEnableA && va) begin
      m_mem[wb][addressA] = dataInA; m_wr[wb][addressA] = 1;
    end
    if (writeEnableB && vb) begin
      m_mem[rb][addressB] = dataInB; m_wr[rb][addressB] = 1;
    end
    req = commitA || auto_c;
    if (req && va) begin
      if (auto_c || commitLengthA == 0 || int'(commitLengthA) > D) len = D;
      else len = int'(commitLengthA);
      q_len.push_back(len);
      commits++;
    end
    if (releaseB && vb) begin
      void'(q_len.pop_front());
      releases++;
    end
    m_ovf = (req && !va) || (m_ovf && !clearErrors);
    m_unf = (releaseB && !vb) || (m_unf && !clearErrors);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bankValidA !== 1'b1) begin bad++; $display("FAIL reset_validA got=%b want=1", bankValidA); end
    total++; if (bankValidB !== 1'b0) begin bad++; $display("FAIL reset_validB got=%b want=0", bankValidB); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    total++; if (bankLengthB !== 5'd0) begin bad++; $display("FAIL reset_lenB got=%0d want=0", bankLengthB); end
    total++; if (dataOutA !== 32'd0 || dataOutB !== 32'd0) begin bad++; $display("FAIL reset_dout got=%h/%h want=0/0", dataOutA, dataOutB); end
    total++; if (overflowError !== 1'b0 || underflowError !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", overflowError, underflowError); end
    rst_n = 1;
  endtask

  task automatic test_fill_commit();
    for (int i = 0; i < 10; i++) begin
      writeEnableA = 1; addressA = AW'(i); dataInA = 32'hA5A5_0000 + i;
      tick();
    end
    idle(); commitA = 1; commitLengthA = 5'd10;
    tick();
    idle();
    total++; if (bankValidB !== 1'b1) begin bad++; $display("FAIL commit_validB got=%b want=1", bankValidB); end
    total++; if (bankLengthB !== 5'd10) begin bad++; $display("FAIL commit_lenB got=%0d want=10", bankLengthB); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL commit_occ got=%0d want=1", occupancy); end
    addressB = 4'd3;
    tick();
    total++; if (dataOutB !== 32'hA5A5_0003) begin bad++; $display("FAIL readB_addr3 got=%h want=a5a50003", dataOutB); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 3; i++) begin
      idle(); commitA = 1; commitLengthA = 5'd1;
      tick();
    end
    idle();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d want=4", occupancy); end
    total++; if (bankValidA !== 1'b0) begin bad++; $display("FAIL full_validA got=%b want=0", bankValidA); end
    writeEnableA = 1; addressA = 4'd0; dataInA = 32'hDEAD_BEEF;
    tick();
    idle(); addressB = 4'd0;
    tick();
    total++; if (dataOutB !== 32'hA5A5_0000) begin bad++; $display("FAIL dropped_write got=%h want=a5a50000", dataOutB); end
    commitA = 1; commitLengthA = 5'd3;
    tick();
    idle();
    total++; if (overflowError !== 1'b1) begin bad++; $display("FAIL overflow got=%b want=1", overflowError); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL overflow_occ got=%0d want=4", occupancy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    commitA = 1; commitLengthA = 5'd5; tick();
    commitLengthA = 5'd7; tick();
    commitLengthA = 5'd9; releaseB = 1; tick();
    idle();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_occ got=%0d want=2", occupancy); end
    total++; if (bankLengthB !== 5'd7) begin bad++; $display("FAIL b2b_lenB got=%0d want=7", bankLengthB); end
    releaseB = 1; tick();
    idle();
    total++; if (bankLengthB !== 5'd9) begin bad++; $display("FAIL b2b_next_len got=%0d want=9", bankLengthB); end
  endtask

  task automatic test_errors();
    do_reset();
    releaseB = 1; tick();
    idle();
    total++; if (underflowError !== 1'b1) begin bad++; $display("FAIL underflow got=%b want=1", underflowError); end
    total++; if (occupancy !== 3'd0 || bankValidA !== 1'b1) begin bad++; $display("FAIL underflow_state got=%0d/%b want=0/1", occupancy, bankValidA); end
    clearErrors = 1; tick();
    idle();
    total++; if (underflowError !== 1'b0) begin bad++; $display("FAIL clear got=%b want=0", underflowError); end
    releaseB = 1; clearErrors = 1; tick();
    idle();
    total++; if (underflowError !== 1'b1) begin bad++; $display("FAIL err_over_clear got=%b want=1", underflowError); end
    commitA = 1; releaseB = 1; commitLengthA = 5'd4; tick();
    idle();
    total++; if (occupancy !== 3'd1 || bankLengthB !== 5'd4) begin bad++; $display("FAIL empty_commit_release got=%0d/%0d want=1/4", occupancy, bankLengthB); end
  endtask

  task automatic test_autocommit_clamp();
    do_reset();
    writeEnableA = 1; addressA = 4'd15; dataInA = 32'h1234_5678; tick();
    idle();
    total++; if (occupancy !== (AUTO ? 3'd1 : 3'd0)) begin bad++; $display("FAIL autocommit_occ got=%0d want=%0d", occupancy, AUTO); end
    total++; if (bankLengthB !== (AUTO ? 5'd16 : 5'd0)) begin bad++; $display("FAIL autocommit_len got=%0d want=%0d", bankLengthB, AUTO ? 16 : 0); end
    do_reset();
    commitA = 1; commitLengthA = 5'd0; tick();
    idle();
    total++; if (bankLengthB !== 5'd16) begin bad++; $display("FAIL clamp_zero got=%0d want=16", bankLengthB); end
    commitA = 1; commitLengthA = 5'd20; releaseB = 1; tick();
    idle();
    total++; if (bankLengthB !== 5'd16) begin bad++; $display("FAIL clamp_high got=%0d want=16", bankLengthB); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      commitA = 1; commitLengthA = 5'd8; tick();
    end
    idle();
    writeEnableA = 1; addressA = 4'd2; dataInA = 32'h0BAD_F00D; addressB = 4'd2;
    tick(); tick();
    #2;
    rst_n = 0;
    #1;
    total++; if (bankValidA !== 1'b1 || bankValidB !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL async_reset_own got=%b/%b/%0d want=1/0/0", bankValidA, bankValidB, occupancy); end
    total++; if (bankLengthB !== 5'd0 || dataOutA !== 32'd0 || dataOutB !== 32'd0) begin bad++; $display("FAIL async_reset_data got=%0d/%h/%h want=0/0/0", bankLengthB, dataOutA, dataOutB); end
    idle();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    int occ;
    for (int n = 0; n < 1500; n++) begin
      writeEnableA  = ($urandom_range(0, 1) == 1);
      addressA      = AW'($urandom_range(0, D - 1));
      dataInA       = $urandom;
      writeEnableB  = ($urandom_range(0, 3) == 0);
      addressB      = AW'($urandom_range(0, D - 1));
      dataInB       = $urandom;
      commitA       = ($urandom_range(0, 3) == 0);
      commitLengthA = 5'($urandom_range(0, 31));
      releaseB      = ($urandom_range(0, 3) == 0);
      clearErrors   = ($urandom_range(0, 15) == 0);
      tick();
      occ = commits - releases;
      total++; if (occupancy !== 3'(occ)) begin bad++; $display("FAIL rnd_occ n=%0d got=%0d want=%0d", n, occupancy, occ); end
      total++; if (bankValidA !== (occ < NB) || bankValidB !== (occ > 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b%b want=%b%b", n, bankValidA, bankValidB, occ < NB, occ > 0); end
      total++; if (bankLengthB !== 5'(occ > 0 ? q_len[0] : 0)) begin bad++; $display("FAIL rnd_lenB n=%0d got=%0d want=%0d", n, bankLengthB, occ > 0 ? q_len[0] : 0); end
      total++; if (overflowError !== m_ovf || underflowError !== m_unf) begin bad++; $display("FAIL rnd_err n=%0d got=%b%b want=%b%b", n, overflowError, underflowError, m_ovf, m_unf); end
      if (k_doa) begin
        total++; if (dataOutA !== e_doa) begin bad++; $display("FAIL rnd_doutA n=%0d got=%h want=%h", n, dataOutA, e_doa); end
      end
      if (k_dob) begin
        total++; if (dataOutB !== e_dob) begin bad++; $display("FAIL rnd_doutB n=%0d got=%h want=%h", n, dataOutB, e_dob); end
      end
    end
    idle();
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < D; a++) begin
        m_wr[b][a] = 0; m_mem[b][a] = '0;
      end
    end
    test_reset();
    test_fill_commit();
    test_full_overflow();
    test_back_to_back();
    test_errors();
    test_autocommit_clamp();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
